dmem_lsu: RTL and testbench
===========================

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have a single clock, clk_i; reset_i SHALL be synchronous and active-high.
REQ-002 Ports (name  direction  width  meaning):
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- req_valid_i  in  1  pipeline access request valid
- req_ready_o  out  1  unit can accept a request
- req_addr_i  in  32  byte address (ALU output)
- req_wr_i  in  1  1 = store, 0 = load
- req_size_i  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = reserved
- req_signed_i  in  1  sign-extend load data
- req_wr_data_i  in  32  store data, LSB-justified
- rsp_valid_o  out  1  response strobe, one cycle
- rsp_rd_data_o  out  32  extended load data
- rsp_misaligned_o  out  1  access rejected as misaligned or reserved size
- mem_valid_o  out  1  bus request valid
- mem_ready_i  in  1  bus accepts request
- mem_addr_o  out  32  word address, bits [1:0] = 0
- mem_we_o  out  1  bus write
- mem_wstrb_o  out  4  byte-lane write strobes
- mem_wdata_o  out  32  lane-aligned write data
- mem_rdata_valid_i  in  1  read data valid
- mem_rdata_i  in  32  read word

Function
REQ-003 The state machine SHALL have four states: IDLE, MEM_REQ, MEM_WAIT and RESP.
REQ-004 req_ready_o SHALL be 1 only in IDLE; a request is accepted when req_valid_i and req_ready_o are both 1.
REQ-005 On acceptance, address, wr, size, signed and wr_data SHALL be latched; later input changes SHALL have no effect.
REQ-006 A request SHALL be misaligned when any of the following holds:
- size = 1 and addr[0] = 1
- size = 2 and addr[1:0] != 0
- size = 3
REQ-007 A misaligned request SHALL go IDLE -> RESP with rsp_misaligned_o = 1 and rsp_rd_data_o = 0, and SHALL produce no bus activity.
REQ-008 An aligned request SHALL go IDLE -> MEM_REQ.
REQ-009 In MEM_REQ, mem_valid_o SHALL be 1, mem_addr_o SHALL be {addr[31:2], 2'b00}, and mem_we_o SHALL equal the latched wr; all bus outputs SHALL be held stable until mem_ready_i = 1.
REQ-010 Store strobes SHALL be:
- byte: 1 << addr[1:0]
- half: 4'b0011 when addr[1] = 0, 4'b1100 when addr[1] = 1
- word: 4'b1111
REQ-011 Store data SHALL be shifted left by 8*addr[1:0] bits for byte and 16*addr[1] bits for half; word data SHALL be unshifted.
REQ-012 For loads, mem_wstrb_o SHALL be 0.
REQ-013 On the bus handshake, a store SHALL go MEM_REQ -> RESP and a load SHALL go MEM_REQ -> MEM_WAIT.
REQ-014 In MEM_WAIT, mem_valid_o SHALL be 0; the unit SHALL stay in MEM_WAIT until mem_rdata_valid_i = 1, then capture mem_rdata_i and go to RESP.
REQ-015 mem_rdata_valid_i SHALL be ignored in every state other than MEM_WAIT.
REQ-016 Load extraction: byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16]; word = rdata unchanged. Byte and half results SHALL be sign-extended when signed = 1, else zero-extended.
REQ-017 In RESP, rsp_valid_o SHALL be 1 for exactly one cycle, then the unit SHALL return to IDLE; responses have no backpressure.
REQ-018 For stores, rsp_rd_data_o SHALL be 0.
REQ-019 rsp_rd_data_o and rsp_misaligned_o SHALL be 0 whenever rsp_valid_o = 0.
REQ-020 Minimum latency from the acceptance cycle to rsp_valid_o SHALL be: misaligned 1 cycle, store 2 cycles, load 3 cycles.
REQ-021 No new request SHALL be accepted until the cycle after RESP, so at most one access is outstanding.

Reset
REQ-022 While reset_i = 1, the state SHALL go to IDLE on the next edge, and all outputs SHALL be 0 except req_ready_o = 1 once in IDLE.
REQ-023 Reset asserted in MEM_REQ or MEM_WAIT SHALL abort the access: mem_valid_o = 0 from the next cycle, no response is issued, and a late mem_rdata_valid_i SHALL be ignored.

Verification
REQ-024 Load byte, signed: addr 0x1003, memory word 0x80FF_1234, mem_ready_i = 1 immediately, rdata_valid on the next cycle -> mem_addr_o 0x1000, mem_wstrb_o 0, rsp_rd_data_o 0xFFFF_FF80 three cycles after acceptance.
REQ-025 Load half, unsigned: addr 0x2002, rdata 0x8001_0000 -> rsp_rd_data_o 0x0000_8001.
REQ-026 Store byte: addr 0x3001, data 0x0000_00AB -> mem_wstrb_o 4'b0010, mem_wdata_o 0x0000_AB00, mem_we_o 1; store half at 0x3002 with data 0x1234 -> mem_wstrb_o 4'b1100, mem_wdata_o 0x1234_0000.
REQ-027 Misaligned word load at 0x4002 -> rsp_valid_o and rsp_misaligned_o one cycle after acceptance, rsp_rd_data_o 0, mem_valid_o never asserted.
REQ-028 Bus stall: mem_ready_i held 0 for 5 cycles -> mem_valid_o, mem_addr_o and mem_wdata_o stable throughout and req_ready_o 0; response follows the handshake.
REQ-029 Reset in MEM_WAIT, then mem_rdata_valid_i pulse -> no rsp_valid_o, req_ready_o 1, and the next request completes normally.

Source files
------------

// File: rtl/dmem_lsu_if.sv
// Pipeline-side request/response and data-bus signals of the load/store unit.
// The slave modport is the LSU; the master modport is the pipeline plus memory environment.
interface dmem_lsu_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_wr_i;
  logic [1:0]  req_size_i;
  logic        req_signed_i;
  logic [31:0] req_wr_data_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rd_data_o;
  logic        rsp_misaligned_o;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rdata_valid_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, req_addr_i, req_wr_i, req_size_i, req_signed_i, req_wr_data_i,
    input  mem_ready_i, mem_rdata_valid_i, mem_rdata_i,
    output req_ready_o, rsp_valid_o, rsp_rd_data_o, rsp_misaligned_o,
    output mem_valid_o, mem_addr_o, mem_we_o, mem_wstrb_o, mem_wdata_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_wr_i, req_size_i, req_signed_i, req_wr_data_i,
    output mem_ready_i, mem_rdata_valid_i, mem_rdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rd_data_o, rsp_misaligned_o,
    input  mem_valid_o, mem_addr_o, mem_we_o, mem_wstrb_o, mem_wdata_o
  );
endinterface

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: one outstanding access, byte/half/word alignment,
// lane steering for stores and sign/zero extension for loads. All outputs registered.
module dmem_lsu (
  input  logic      clk_i,
  input  logic      reset_i,
  dmem_lsu_if.slave lsu
);
  // state    | meaning
  // IDLE     | ready to accept a request
  // MEM_REQ  | bus request held until mem_ready_i
  // MEM_WAIT | load issued, waiting for mem_rdata_valid_i
  // RESP     | one-cycle response strobe
  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT, RESP} state_t;

  state_t     state;
  logic [1:0] addr_lo_q;
  logic [1:0] size_q;
  logic       wr_q;
  logic       signed_q;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd1:    return lo[0];
      2'd2:    return lo != 2'b00;
      2'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'd0:    return 4'b0001 << lo;
      2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [1:0] lo,
                                             input logic [31:0] d);
    case (size)
      2'd0:    return d << {lo, 3'b000};
      2'd1:    return d << {lo[1], 4'b0000};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] lo,
                                               input logic [1:0] size, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = w[{lo[1], 4'b0000} +: 16];
    case (size)
      2'd0:    return {{24{sg & b[7]}}, b};
      2'd1:    return {{16{sg & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state                <= IDLE;
      lsu.req_ready_o      <= 1'b1;
      lsu.rsp_valid_o      <= 1'b0;
      lsu.rsp_rd_data_o    <= 32'h0;
      lsu.rsp_misaligned_o <= 1'b0;
      lsu.mem_valid_o      <= 1'b0;
      lsu.mem_addr_o       <= 32'h0;
      lsu.mem_we_o         <= 1'b0;
      lsu.mem_wstrb_o      <= 4'h0;
      lsu.mem_wdata_o      <= 32'h0;
      addr_lo_q            <= 2'b00;
      size_q               <= 2'b00;
      wr_q                 <= 1'b0;
      signed_q             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu.req_valid_i && lsu.req_ready_o) begin
            addr_lo_q       <= lsu.req_addr_i[1:0];
            size_q          <= lsu.req_size_i;
            wr_q            <= lsu.req_wr_i;
            signed_q        <= lsu.req_signed_i;
            lsu.req_ready_o <= 1'b0;
            if (is_misaligned(lsu.req_size_i, lsu.req_addr_i[1:0])) begin
              state                <= RESP;
              lsu.rsp_valid_o      <= 1'b1;
              lsu.rsp_misaligned_o <= 1'b1;
              lsu.rsp_rd_data_o    <= 32'h0;
            end else begin
              // Bus fields are fixed here and held untouched until the handshake.
              state           <= MEM_REQ;
              lsu.mem_valid_o <= 1'b1;
              lsu.mem_addr_o  <= {lsu.req_addr_i[31:2], 2'b00};
              lsu.mem_we_o    <= lsu.req_wr_i;
              lsu.mem_wstrb_o <= lsu.req_wr_i ?
                                 store_strb(lsu.req_size_i, lsu.req_addr_i[1:0]) : 4'h0;
              lsu.mem_wdata_o <= lsu.req_wr_i ?
                                 store_data(lsu.req_size_i, lsu.req_addr_i[1:0],
                                            lsu.req_wr_data_i) : 32'h0;
            end
          end
        end
        MEM_REQ: begin
          if (lsu.mem_ready_i) begin
            lsu.mem_valid_o <= 1'b0;
            lsu.mem_addr_o  <= 32'h0;
            lsu.mem_we_o    <= 1'b0;
            lsu.mem_wstrb_o <= 4'h0;
            lsu.mem_wdata_o <= 32'h0;
            if (wr_q) begin
              state             <= RESP;
              lsu.rsp_valid_o   <= 1'b1;
              lsu.rsp_rd_data_o <= 32'h0;
            end else begin
              state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (lsu.mem_rdata_valid_i) begin
            state             <= RESP;
            lsu.rsp_valid_o   <= 1'b1;
            lsu.rsp_rd_data_o <= load_extract(lsu.mem_rdata_i, addr_lo_q, size_q, signed_q);
          end
        end
        RESP: begin
          state                <= IDLE;
          lsu.rsp_valid_o      <= 1'b0;
          lsu.rsp_rd_data_o    <= 32'h0;
          lsu.rsp_misaligned_o <= 1'b0;
          lsu.req_ready_o      <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: loads, stores, misalignment, bus stall, reset abort.
module tb_dmem_lsu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  dmem_lsu_if lsu_bus();

  dmem_lsu dut (
    .clk_i  (clk),
    .reset_i(rst),
    .lsu    (lsu_bus)
  );

  always #5 clk = ~clk;

  task automatic drive_req(input logic [31:0] addr, input logic wr, input logic [1:0] size,
                           input logic sg, input logic [31:0] wdata);
    lsu_bus.req_valid_i   = 1'b1;
    lsu_bus.req_addr_i    = addr;
    lsu_bus.req_wr_i      = wr;
    lsu_bus.req_size_i    = size;
    lsu_bus.req_signed_i  = sg;
    lsu_bus.req_wr_data_i = wdata;
  endtask

  // Garbage on the request inputs after acceptance must not leak into the access.
  task automatic scramble_req();
    lsu_bus.req_valid_i   = 1'b0;
    lsu_bus.req_addr_i    = 32'hFFFF_FFFF;
    lsu_bus.req_wr_i      = ~lsu_bus.req_wr_i;
    lsu_bus.req_size_i    = 2'd3;
    lsu_bus.req_signed_i  = ~lsu_bus.req_signed_i;
    lsu_bus.req_wr_data_i = 32'h5A5A_5A5A;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (lsu_bus.req_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready got %b expected 1", lsu_bus.req_ready_o);
    end
    checks++;
    if ({lsu_bus.rsp_valid_o, lsu_bus.rsp_misaligned_o, lsu_bus.mem_valid_o, lsu_bus.mem_we_o} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes got %b expected 0000",
        {lsu_bus.rsp_valid_o, lsu_bus.rsp_misaligned_o, lsu_bus.mem_valid_o, lsu_bus.mem_we_o});
    end
    checks++;
    if ({lsu_bus.rsp_rd_data_o, lsu_bus.mem_addr_o, lsu_bus.mem_wdata_o, lsu_bus.mem_wstrb_o} !== 100'h0) begin
      errors++; $display("FAIL reset_data got rd=%h addr=%h wd=%h st=%h expected all 0",
        lsu_bus.rsp_rd_data_o, lsu_bus.mem_addr_o, lsu_bus.mem_wdata_o, lsu_bus.mem_wstrb_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_loads();
    logic [31:0] la [6] = '{32'h1003, 32'h2002, 32'h1001, 32'h2000, 32'h5004, 32'h1002};
    logic [1:0]  ls [6] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0};
    logic        lg [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] lw [6] = '{32'h80FF_1234, 32'h8001_0000, 32'h80FF_1234,
                            32'h1234_ABCD, 32'hCAFE_F00D, 32'h80FF_1234};
    logic [31:0] lx [6] = '{32'hFFFF_FF80, 32'h0000_8001, 32'h0000_0012,
                            32'hFFFF_ABCD, 32'hCAFE_F00D, 32'hFFFF_FFFF};
    logic [31:0] ea [6] = '{32'h1000, 32'h2000, 32'h1000, 32'h2000, 32'h5004, 32'h1000};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (lsu_bus.rsp_valid_o !== 1'b0 || lsu_bus.rsp_rd_data_o !== 32'h0) begin
        errors++; $display("FAIL load_idle_rsp[%0d] got v=%b d=%h expected 0/0", i,
          lsu_bus.rsp_valid_o, lsu_bus.rsp_rd_data_o);
      end
      lsu_bus.mem_ready_i = 1'b1;
      drive_req(la[i], 1'b0, ls[i], lg[i], 32'h1357_9BDF);
      @(negedge clk);
      scramble_req();
      checks++;
      if (lsu_bus.mem_valid_o !== 1'b1 || lsu_bus.mem_addr_o !== ea[i] ||
          lsu_bus.mem_wstrb_o !== 4'h0 || lsu_bus.mem_we_o !== 1'b0 || lsu_bus.req_ready_o !== 1'b0) begin
        errors++; $display("FAIL load_bus[%0d] got v=%b a=%h st=%h we=%b rdy=%b expected 1 %h 0 0 0", i,
          lsu_bus.mem_valid_o, lsu_bus.mem_addr_o, lsu_bus.mem_wstrb_o, lsu_bus.mem_we_o,
          lsu_bus.req_ready_o, ea[i]);
      end
      @(negedge clk);
      lsu_bus.mem_ready_i = 1'b0;
      checks++;
      if (lsu_bus.mem_valid_o !== 1'b0 || lsu_bus.rsp_valid_o !== 1'b0) begin
        errors++; $display("FAIL load_wait[%0d] got mv=%b rv=%b expected 0 0", i,
          lsu_bus.mem_valid_o, lsu_bus.rsp_valid_o);
      end
      lsu_bus.mem_rdata_valid_i = 1'b1;
      lsu_bus.mem_rdata_i       = lw[i];
      @(negedge clk);
      lsu_bus.mem_rdata_valid_i = 1'b0;
      lsu_bus.mem_rdata_i       = 32'hDEAD_BEEF;
      checks++;
      if (lsu_bus.rsp_valid_o !== 1'b1 || lsu_bus.rsp_rd_data_o !== lx[i] ||
          lsu_bus.rsp_misaligned_o !== 1'b0) begin
        errors++; $display("FAIL load_data[%0d] got v=%b d=%h m=%b expected 1 %h 0", i,
          lsu_bus.rsp_valid_o, lsu_bus.rsp_rd_data_o, lsu_bus.rsp_misaligned_o, lx[i]);
      end
    end
  endtask

  task automatic test_stores();
    logic [31:0] sa [6] = '{32'h3001, 32'h3002, 32'h3000, 32'h3004, 32'h3003, 32'h3000};
    logic [1:0]  ss [6] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] sd [6] = '{32'h0000_00AB, 32'h0000_1234, 32'h0000_5678,
                            32'hDEAD_BEEF, 32'h0000_00CD, 32'h0000_0011};
    logic [3:0]  es [6] = '{4'b0010, 4'b1100, 4'b0011, 4'b1111, 4'b1000, 4'b0001};
    logic [31:0] ed [6] = '{32'h0000_AB00, 32'h1234_0000, 32'h0000_5678,
                            32'hDEAD_BEEF, 32'hCD00_0000, 32'h0000_0011};
    logic [31:0] ea [6] = '{32'h3000, 32'h3000, 32'h3000, 32'h3004, 32'h3000, 32'h3000};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lsu_bus.mem_ready_i = 1'b1;
      drive_req(sa[i], 1'b1, ss[i], 1'b0, sd[i]);
      @(negedge clk);
      scramble_req();
      checks++;
      if (lsu_bus.mem_valid_o !== 1'b1 || lsu_bus.mem_we_o !== 1'b1 || lsu_bus.mem_addr_o !== ea[i] ||
          lsu_bus.mem_wstrb_o !== es[i] || lsu_bus.mem_wdata_o !== ed[i]) begin
        errors++; $display("FAIL store_bus[%0d] got v=%b we=%b a=%h st=%b wd=%h expected 1 1 %h %b %h", i,
          lsu_bus.mem_valid_o, lsu_bus.mem_we_o, lsu_bus.mem_addr_o, lsu_bus.mem_wstrb_o,
          lsu_bus.mem_wdata_o, ea[i], es[i], ed[i]);
      end
      @(negedge clk);
      lsu_bus.mem_ready_i = 1'b0;
      checks++;
      if (lsu_bus.rsp_valid_o !== 1'b1 || lsu_bus.rsp_rd_data_o !== 32'h0 ||
          lsu_bus.rsp_misaligned_o !== 1'b0 || lsu_bus.mem_valid_o !== 1'b0) begin
        errors++; $display("FAIL store_rsp[%0d] got v=%b d=%h m=%b mv=%b expected 1 0 0 0", i,
          lsu_bus.rsp_valid_o, lsu_bus.rsp_rd_data_o, lsu_bus.rsp_misaligned_o, lsu_bus.mem_valid_o);
      end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] ma [4] = '{32'h4002, 32'h4001, 32'h4000, 32'h4003};
    logic [1:0]  ms [4] = '{2'd2, 2'd1, 2'd3, 2'd1};
    logic        mw [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lsu_bus.mem_ready_i = 1'b1;
      drive_req(ma[i], mw[i], ms[i], 1'b1, 32'hFFFF_FFFF);
      @(negedge clk);
      scramble_req();
      checks++;
      if (lsu_bus.rsp_valid_o !== 1'b1 || lsu_bus.rsp_misaligned_o !== 1'b1 ||
          lsu_bus.rsp_rd_data_o !== 32'h0 || lsu_bus.mem_valid_o !== 1'b0) begin
        errors++; $display("FAIL misaligned_rsp[%0d] got v=%b m=%b d=%h mv=%b expected 1 1 0 0", i,
          lsu_bus.rsp_valid_o, lsu_bus.rsp_misaligned_o, lsu_bus.rsp_rd_data_o, lsu_bus.mem_valid_o);
      end
      @(negedge clk);
      checks++;
      if (lsu_bus.rsp_valid_o !== 1'b0 || lsu_bus.rsp_misaligned_o !== 1'b0 ||
          lsu_bus.mem_valid_o !== 1'b0 || lsu_bus.req_ready_o !== 1'b1) begin
        errors++; $display("FAIL misaligned_after[%0d] got v=%b m=%b mv=%b rdy=%b expected 0 0 0 1", i,
          lsu_bus.rsp_valid_o, lsu_bus.rsp_misaligned_o, lsu_bus.mem_valid_o, lsu_bus.req_ready_o);
      end
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    lsu_bus.mem_ready_i = 1'b0;
    drive_req(32'h3001, 1'b1, 2'd0, 1'b0, 32'h0000_00AB);
    @(negedge clk);
    scramble_req();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (lsu_bus.mem_valid_o !== 1'b1 || lsu_bus.mem_addr_o !== 32'h3000 ||
          lsu_bus.mem_wdata_o !== 32'h0000_AB00 || lsu_bus.req_ready_o !== 1'b0 ||
          lsu_bus.rsp_valid_o !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b a=%h wd=%h rdy=%b rv=%b expected 1 3000 0000ab00 0 0", c,
          lsu_bus.mem_valid_o, lsu_bus.mem_addr_o, lsu_bus.mem_wdata_o, lsu_bus.req_ready_o,
          lsu_bus.rsp_valid_o);
      end
      @(negedge clk);
    end
    lsu_bus.mem_ready_i = 1'b1;
    @(negedge clk);
    lsu_bus.mem_ready_i = 1'b0;
    checks++;
    if (lsu_bus.rsp_valid_o !== 1'b1) begin
      errors++; $display("FAIL stall_store_rsp got %b expected 1", lsu_bus.rsp_valid_o);
    end
    // Load stall with read data strobing early: must be ignored outside MEM_WAIT.
    @(negedge clk);
    drive_req(32'h2002, 1'b0, 2'd1, 1'b0, 32'h0);
    @(negedge clk);
    scramble_req();
    lsu_bus.mem_rdata_valid_i = 1'b1;
    lsu_bus.mem_rdata_i       = 32'h1111_2222;
    repeat (3) @(negedge clk);
    checks++;
    if (lsu_bus.rsp_valid_o !== 1'b0 || lsu_bus.mem_valid_o !== 1'b1) begin
      errors++; $display("FAIL stall_early_rdata got rv=%b mv=%b expected 0 1",
        lsu_bus.rsp_valid_o, lsu_bus.mem_valid_o);
    end
    lsu_bus.mem_rdata_valid_i = 1'b0;
    lsu_bus.mem_ready_i       = 1'b1;
    @(negedge clk);
    lsu_bus.mem_ready_i       = 1'b0;
    lsu_bus.mem_rdata_valid_i = 1'b1;
    lsu_bus.mem_rdata_i       = 32'h8001_0000;
    @(negedge clk);
    lsu_bus.mem_rdata_valid_i = 1'b0;
    checks++;
    if (lsu_bus.rsp_valid_o !== 1'b1 || lsu_bus.rsp_rd_data_o !== 32'h0000_8001) begin
      errors++; $display("FAIL stall_load_rsp got v=%b d=%h expected 1 00008001",
        lsu_bus.rsp_valid_o, lsu_bus.rsp_rd_data_o);
    end
  endtask

  task automatic test_reset_abort();
    // Abort from MEM_WAIT, then a late read-data pulse.
    @(negedge clk);
    lsu_bus.mem_ready_i = 1'b1;
    drive_req(32'h1000, 1'b0, 2'd2, 1'b0, 32'h0);
    @(negedge clk);
    scramble_req();
    @(negedge clk);
    lsu_bus.mem_ready_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (lsu_bus.mem_valid_o !== 1'b0 || lsu_bus.rsp_valid_o !== 1'b0 || lsu_bus.req_ready_o !== 1'b1) begin
      errors++; $display("FAIL abort_wait got mv=%b rv=%b rdy=%b expected 0 0 1",
        lsu_bus.mem_valid_o, lsu_bus.rsp_valid_o, lsu_bus.req_ready_o);
    end
    lsu_bus.mem_rdata_valid_i = 1'b1;
    lsu_bus.mem_rdata_i       = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (lsu_bus.rsp_valid_o !== 1'b0 || lsu_bus.req_ready_o !== 1'b1) begin
        errors++; $display("FAIL abort_late_rdata got rv=%b rdy=%b expected 0 1",
          lsu_bus.rsp_valid_o, lsu_bus.req_ready_o);
      end
    end
    lsu_bus.mem_rdata_valid_i = 1'b0;
    // Abort from MEM_REQ while the bus is stalled.
    drive_req(32'h6000, 1'b1, 2'd2, 1'b0, 32'h0BAD_0BAD);
    @(negedge clk);
    scramble_req();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lsu_bus.mem_ready_i = 1'b1;
    checks++;
    if (lsu_bus.mem_valid_o !== 1'b0 || lsu_bus.req_ready_o !== 1'b1 || lsu_bus.mem_wstrb_o !== 4'h0) begin
      errors++; $display("FAIL abort_req got mv=%b rdy=%b st=%b expected 0 1 0000",
        lsu_bus.mem_valid_o, lsu_bus.req_ready_o, lsu_bus.mem_wstrb_o);
    end
    @(negedge clk);
    checks++;
    if (lsu_bus.rsp_valid_o !== 1'b0) begin
      errors++; $display("FAIL abort_req_rsp got %b expected 0", lsu_bus.rsp_valid_o);
    end
    // Normal load afterwards.
    drive_req(32'h1003, 1'b0, 2'd0, 1'b1, 32'h0);
    @(negedge clk);
    scramble_req();
    @(negedge clk);
    lsu_bus.mem_ready_i       = 1'b0;
    lsu_bus.mem_rdata_valid_i = 1'b1;
    lsu_bus.mem_rdata_i       = 32'h80FF_1234;
    @(negedge clk);
    lsu_bus.mem_rdata_valid_i = 1'b0;
    checks++;
    if (lsu_bus.rsp_valid_o !== 1'b1 || lsu_bus.rsp_rd_data_o !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL abort_recover got v=%b d=%h expected 1 ffffff80",
        lsu_bus.rsp_valid_o, lsu_bus.rsp_rd_data_o);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    @(negedge clk);
    drive_req(32'h7001, 1'b0, 2'd2, 1'b0, 32'h0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (lsu_bus.rsp_valid_o !== exp_v[c] || lsu_bus.req_ready_o !== ~exp_v[c]) begin
        errors++; $display("FAIL back_to_back[%0d] got rv=%b rdy=%b expected %b %b", c,
          lsu_bus.rsp_valid_o, lsu_bus.req_ready_o, exp_v[c], ~exp_v[c]);
      end
    end
    lsu_bus.req_valid_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    lsu_bus.req_valid_i       = 1'b0;
    lsu_bus.req_addr_i        = 32'h0;
    lsu_bus.req_wr_i          = 1'b0;
    lsu_bus.req_size_i        = 2'd0;
    lsu_bus.req_signed_i      = 1'b0;
    lsu_bus.req_wr_data_i     = 32'h0;
    lsu_bus.mem_ready_i       = 1'b0;
    lsu_bus.mem_rdata_valid_i = 1'b0;
    lsu_bus.mem_rdata_i       = 32'h0;
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
